// File: rtl/upstream_order_gate_pkg.sv
// Shared constants, types and FSM encodings for the upstream order gate.
package upstream_pkg;

  localparam int CLIENT_W    = 5;
  localparam int AMOUNT_W    = 16;
  localparam int NUM_CLIENTS = 1 << CLIENT_W;

  localparam logic [AMOUNT_W-1:0] CREDIT_INIT_DEFAULT = 16'h0400;

  typedef logic [CLIENT_W-1:0] client_id_t;
  typedef logic [AMOUNT_W-1:0] amount_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD,
    EXEC,
    RESP
  } gate_state_t;

  typedef enum logic {
    ORDER,
    CANCEL
  } txn_kind_t;

endpackage

// File: rtl/upstream_order_gate_credit_ram.sv
// Single-port credit memory: synchronous write, registered read (1-cycle latency).
// Contents are undefined until the gate's init sweep has written every entry.
module credit_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read share the one address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/upstream_order_gate.sv
// Per-client credit gate: orders are debited against a client's credit and
// answered accept/reject; cancel notices restore credit (saturating).
module upstream_order_gate
  import upstream_pkg::*;
#(
  parameter int                  NUM_CLIENTS = upstream_pkg::NUM_CLIENTS,
  parameter int                  CLIENT_W    = upstream_pkg::CLIENT_W,
  parameter int                  AMOUNT_W    = upstream_pkg::AMOUNT_W,
  parameter logic [AMOUNT_W-1:0] CREDIT_INIT = upstream_pkg::CREDIT_INIT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                order_valid,
  output logic                order_ready,
  input  logic [CLIENT_W-1:0] order_client_id,
  input  logic [AMOUNT_W-1:0] order_amount,
  input  logic                cancel_valid,
  output logic                cancel_ready,
  input  logic [CLIENT_W-1:0] cancel_client_id,
  input  logic [AMOUNT_W-1:0] cancel_amount,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_accept,
  output logic [CLIENT_W-1:0] resp_client_id,
  output logic [AMOUNT_W-1:0] resp_remaining,
  output logic                init_done
);

  localparam logic [CLIENT_W-1:0] LAST_ID = CLIENT_W'(NUM_CLIENTS - 1);

  gate_state_t         state_q, state_d;
  logic [CLIENT_W-1:0] sweep_q, sweep_d;
  txn_kind_t           kind_q, kind_d;
  logic [CLIENT_W-1:0] client_q, client_d;
  logic [AMOUNT_W-1:0] amount_q, amount_d;
  logic                idle_q, idle_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_accept_q, resp_accept_d;
  logic [CLIENT_W-1:0] resp_client_q, resp_client_d;
  logic [AMOUNT_W-1:0] resp_remaining_q, resp_remaining_d;
  logic                init_done_q, init_done_d;

  logic                ram_we;
  logic [CLIENT_W-1:0] ram_addr;
  logic [AMOUNT_W-1:0] ram_wdata;
  logic [AMOUNT_W-1:0] ram_rdata;
  logic [AMOUNT_W:0]   credit_sum;

  credit_ram #(
    .ADDR_W (CLIENT_W),
    .DATA_W (AMOUNT_W),
    .DEPTH  (NUM_CLIENTS)
  ) u_credit_ram (
    .clk   (clk),
    .we    (ram_we & ~reset),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Cancel restore is computed one bit wider so overflow can saturate.
  assign credit_sum = {1'b0, ram_rdata} + {1'b0, amount_q};

  // Next-state, RAM port and response computation for every FSM state.
  always_comb begin
    state_d          = state_q;
    sweep_d          = sweep_q;
    kind_d           = kind_q;
    client_d         = client_q;
    amount_d         = amount_q;
    resp_valid_d     = resp_valid_q;
    resp_accept_d    = resp_accept_q;
    resp_client_d    = resp_client_q;
    resp_remaining_d = resp_remaining_q;
    init_done_d      = init_done_q;
    ram_we           = 1'b0;
    ram_addr         = client_q;
    ram_wdata        = CREDIT_INIT;

    case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = sweep_q;
        ram_wdata = CREDIT_INIT;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == LAST_ID) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        // Cancel is always ready in IDLE, so cancel_valid alone is a handshake.
        if (cancel_valid) begin
          kind_d   = CANCEL;
          client_d = cancel_client_id;
          amount_d = cancel_amount;
          ram_addr = cancel_client_id;
          state_d  = RD;
        end else if (order_valid) begin
          kind_d   = ORDER;
          client_d = order_client_id;
          amount_d = order_amount;
          ram_addr = order_client_id;
          state_d  = RD;
        end
      end
      RD: begin
        // Read of client_q is captured at the end of this cycle.
        state_d = EXEC;
      end
      EXEC: begin
        ram_we = 1'b1;
        if (kind_q == ORDER) begin
          if (amount_q <= ram_rdata) begin
            ram_wdata     = ram_rdata - amount_q;
            resp_accept_d = 1'b1;
          end else begin
            ram_wdata     = ram_rdata;
            resp_accept_d = 1'b0;
          end
          resp_valid_d     = 1'b1;
          resp_client_d    = client_q;
          resp_remaining_d = ram_wdata;
          state_d          = RESP;
        end else begin
          ram_wdata = credit_sum[AMOUNT_W] ? {AMOUNT_W{1'b1}} : credit_sum[AMOUNT_W-1:0];
          state_d   = IDLE;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = INIT;
        sweep_d = '0;
      end
    endcase

    idle_d = (state_d == IDLE);
  end

  // State, latch and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= INIT;
      sweep_q          <= '0;
      kind_q           <= ORDER;
      client_q         <= '0;
      amount_q         <= '0;
      idle_q           <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_accept_q    <= 1'b0;
      resp_client_q    <= '0;
      resp_remaining_q <= '0;
      init_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      sweep_q          <= sweep_d;
      kind_q           <= kind_d;
      client_q         <= client_d;
      amount_q         <= amount_d;
      idle_q           <= idle_d;
      resp_valid_q     <= resp_valid_d;
      resp_accept_q    <= resp_accept_d;
      resp_client_q    <= resp_client_d;
      resp_remaining_q <= resp_remaining_d;
      init_done_q      <= init_done_d;
    end
  end

  assign cancel_ready   = idle_q;
  assign order_ready    = idle_q & ~cancel_valid;
  assign resp_valid     = resp_valid_q;
  assign resp_accept    = resp_accept_q;
  assign resp_client_id = resp_client_q;
  assign resp_remaining = resp_remaining_q;
  assign init_done      = init_done_q;

endmodule

// File: tb/tb_upstream_order_gate.sv
// Directed-vector bench for upstream_order_gate with a response scoreboard.
module tb_upstream_order_gate;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        order_valid = 1'b0;
  logic        order_ready;
  logic [4:0]  order_client_id = '0;
  logic [15:0] order_amount = '0;
  logic        cancel_valid = 1'b0;
  logic        cancel_ready;
  logic [4:0]  cancel_client_id = '0;
  logic [15:0] cancel_amount = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_accept;
  logic [4:0]  resp_client_id;
  logic [15:0] resp_remaining;
  logic        init_done;

  upstream_order_gate dut (
    .clk              (clk),
    .reset            (reset),
    .order_valid      (order_valid),
    .order_ready      (order_ready),
    .order_client_id  (order_client_id),
    .order_amount     (order_amount),
    .cancel_valid     (cancel_valid),
    .cancel_ready     (cancel_ready),
    .cancel_client_id (cancel_client_id),
    .cancel_amount    (cancel_amount),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_accept      (resp_accept),
    .resp_client_id   (resp_client_id),
    .resp_remaining   (resp_remaining),
    .init_done        (init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        acc;
    logic [4:0]  id;
    logic [15:0] rem;
    int          hs;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every completed response handshake pops one expectation.
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL resp_unexpected: got response id=%0h rem=%0h, none expected", resp_client_id, resp_remaining);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("resp id=%0h accept=%0b remaining=%0h", resp_client_id, resp_accept, resp_remaining);
        check("resp_accept", 32'(resp_accept), 32'(e.acc));
        check("resp_client_id", 32'(resp_client_id), 32'(e.id));
        check("resp_remaining", 32'(resp_remaining), 32'(e.rem));
        if (e.lat) check("resp_latency", cyc - e.hs, 3);
      end
    end
  end

  // Waits (bounded) for order_ready with order_valid held; returns just after the handshake edge.
  task automatic wait_order_hs(output bit ok, output int hs);
    ok = 1'b0;
    hs = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (order_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL order_handshake_timeout: got order_ready=0 expected 1 within 60 cycles");
    end
    hs = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_resp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_timeout: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_order(input logic [4:0] id, input logic [15:0] amt,
                          input logic acc, input logic [15:0] rem, input bit lat);
    bit ok;
    int hs;
    order_client_id = id;
    order_amount    = amt;
    order_valid     = 1'b1;
    wait_order_hs(ok, hs);
    order_valid = 1'b0;
    $display("order id=%0h amount=%0h", id, amt);
    if (ok) exp_q.push_back('{acc: acc, id: id, rem: rem, hs: hs, lat: lat});
    drain_resp();
  endtask

  task automatic do_cancel(input logic [4:0] id, input logic [15:0] amt);
    bit ok;
    ok = 1'b0;
    cancel_client_id = id;
    cancel_amount    = amt;
    cancel_valid     = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cancel_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("cancel_handshake_timeout", 32'(cancel_ready), 1);
    @(posedge clk);
    #1;
    cancel_valid = 1'b0;
    $display("cancel id=%0h amount=%0h", id, amt);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Counts edges from reset release until init_done, checking readies stay low meanwhile.
  task automatic wait_init();
    int n;
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      n = k;
      if (init_done) break;
      if (order_ready || cancel_ready) check("ready_during_init", {30'd0, order_ready, cancel_ready}, 0);
    end
    check("init_latency", n, 32);
    check("init_done", 32'(init_done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int hs;
    int hs_c;

    // Reset values
    @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_readies", {30'd0, order_ready, cancel_ready}, 0);
    check("rst_resp_fields", {15'd0, resp_accept, resp_client_id, resp_remaining}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init();

    // Zero amount always accepted, credit untouched
    do_order(5'h1B, 16'h0000, 1'b1, 16'h0400, 1'b1);

    // Debit then over-limit reject
    do_order(5'h01, 16'h00C5, 1'b1, 16'h033B, 1'b1);
    do_order(5'h01, 16'h05C5, 1'b0, 16'h033B, 1'b1);

    // Saturating cancel then full-scale order
    do_cancel(5'h01, 16'hFF00);
    do_order(5'h01, 16'hFFFF, 1'b1, 16'h0000, 1'b1);

    // Simultaneous cancel and order: cancel first
    cancel_client_id = 5'h01;
    cancel_amount    = 16'h0100;
    cancel_valid     = 1'b1;
    order_client_id  = 5'h01;
    order_amount     = 16'h0080;
    order_valid      = 1'b1;
    @(negedge clk);
    check("prio_order_ready", 32'(order_ready), 0);
    check("prio_cancel_ready", 32'(cancel_ready), 1);
    hs_c = cyc;
    @(posedge clk);
    #1;
    cancel_valid = 1'b0;
    wait_order_hs(ok, hs);
    order_valid = 1'b0;
    check("prio_order_delay", hs - hs_c, 3);
    if (ok) exp_q.push_back('{acc: 1'b1, id: 5'h01, rem: 16'h0080, hs: hs, lat: 1'b1});
    drain_resp();

    // Backpressure on the response
    resp_ready      = 1'b0;
    order_client_id = 5'h02;
    order_amount    = 16'h0010;
    order_valid     = 1'b1;
    wait_order_hs(ok, hs);
    order_valid = 1'b0;
    if (ok) exp_q.push_back('{acc: 1'b1, id: 5'h02, rem: 16'h03F0, hs: hs, lat: 1'b0});
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_resp_valid", 32'(resp_valid), 1);
      check("stall_resp_fields", {15'd0, resp_accept, resp_client_id, resp_remaining}, {15'd0, 1'b1, 5'h02, 16'h03F0});
      check("stall_order_ready", 32'(order_ready), 0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_resp_order_ready", 32'(order_ready), 1);
    check("post_resp_valid", 32'(resp_valid), 0);

    // Reset while an order is in EXEC
    order_client_id = 5'h03;
    order_amount    = 16'h0100;
    order_valid     = 1'b1;
    wait_order_hs(ok, hs);
    order_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 0);
    check("midrst_init_done", 32'(init_done), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init();
    do_order(5'h03, 16'h0000, 1'b1, 16'h0400, 1'b1);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/upstream_order_gate.md
Name: upstream_order_gate

Overview:
- Upstream counterpart of the downstream cancelled-order path.
- Holds a per-client credit memory of NUM_CLIENTS entries, each AMOUNT_W bits wide.
- Checks each incoming order (client_id, amount) against that client's remaining credit, debits it on accept, and returns an accept/reject response.
- Cancel notices from the downstream side restore credit to the same memory.

Parameters:
- NUM_CLIENTS, 32, number of client entries; equals 2**CLIENT_W.
- CLIENT_W, 5, client id width.
- AMOUNT_W, 16, amount and credit width.
- CREDIT_INIT, 16'h0400, credit loaded into every entry during the init sweep.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- order_valid  in  1  order request present.
- order_ready  out  1  gate can take an order this cycle.
- order_client_id  in  CLIENT_W  client of the order.
- order_amount  in  AMOUNT_W  order amount.
- cancel_valid  in  1  cancel notice present.
- cancel_ready  out  1  gate can take a cancel this cycle.
- cancel_client_id  in  CLIENT_W  client of the cancel.
- cancel_amount  in  AMOUNT_W  credit to restore.
- resp_valid  out  1  order response present.
- resp_ready  in  1  consumer accepts the response.
- resp_accept  out  1  1 = order accepted, 0 = rejected.
- resp_client_id  out  CLIENT_W  echoed client id.
- resp_remaining  out  AMOUNT_W  client credit after this order.
- init_done  out  1  init sweep complete.

Behaviour:
- One clock domain. Reset is synchronous and active-high; it is sampled on the clk rising edge.
- Reset values: order_ready=0, cancel_ready=0, resp_valid=0, resp_accept=0, resp_client_id=0, resp_remaining=0, init_done=0, FSM=INIT, sweep address=0.
- FSM states: INIT, IDLE, RD, EXEC, RESP.
- INIT:
  - Writes CREDIT_INIT to address 0..NUM_CLIENTS-1, one entry per cycle, which takes 32 cycles.
  - After the write to address 31, go to IDLE and set init_done=1. init_done stays 1 until the next reset.
  - order_ready and cancel_ready are 0 throughout INIT.
- IDLE:
  - cancel_ready=1. order_ready=!cancel_valid, so a cancel has priority.
  - On a handshake, latch kind (order/cancel), client_id and amount, drive the RAM read address, and go to RD.
  - Both ready signals are 0 in every state other than IDLE.
- RD: wait one cycle for the synchronous RAM read data. Go to EXEC.
- EXEC, order:
  - Accept if amount <= credit; the new credit is credit-amount.
  - Otherwise reject and leave credit unchanged.
  - A zero amount is always accepted with credit unchanged.
  - Write the new credit back, load the resp_* registers, and go to RESP.
- EXEC, cancel:
  - New credit is credit+amount, computed in AMOUNT_W+1 bits and saturated at all-ones.
  - Write it back and go to IDLE. A cancel produces no response.
- RESP:
  - resp_valid=1. resp_* fields stay stable until resp_valid && resp_ready, then go to IDLE with resp_valid=0 on the next cycle.
  - Inputs arriving during RESP are not accepted, because both ready signals are 0.
- Latency:
  - Order handshake at edge T.
  - RD occupies cycle T+1; EXEC writes at edge T+2.
  - resp_valid is high from T+2 and is observable in cycle T+3 with resp_ready=1.
  - Throughput is at most one transaction per 4 cycles for orders and 3 cycles for cancels.
- Client ids index the RAM directly; the full 0..31 range is valid and there is no out-of-range case.
- Reset mid-operation (any state):
  - The in-flight transaction is dropped.
  - resp_valid=0 and init_done=0 from the next cycle.
  - The full INIT sweep reruns.
- Read-during-write is not a concern: the FSM serialises all accesses, so RD never overlaps an EXEC write.

Decomposition:
- Package upstream_pkg:
  - CLIENT_W, AMOUNT_W, NUM_CLIENTS constants.
  - client_id_t and amount_t typedefs.
  - gate_state_t enum {INIT, IDLE, RD, EXEC, RESP}.
  - txn_kind_t enum {ORDER, CANCEL}.
- Sub-module credit_ram:
  - Single-port, 32x16, synchronous write, registered read (1-cycle latency).
  - No reset; it is initialised by the INIT sweep.
- The top holds the FSM, latch registers, compare/subtract/saturating-add logic and response registers.

Test Plan:
- Reset high for 2 cycles, then low: init_done rises exactly 32 cycles after reset deasserts. Ready signals stay 0 until then. An order for client 0x1B, amount 0x0000, gives accept=1, remaining=0x0400.
- Order client 0x01, amount 0x00C5: accept=1, remaining=0x033B, response in the 3rd cycle after the handshake. A second order of 0x05C5 for the same client gives accept=0, remaining=0x033B.
- Cancel client 0x01, amount 0xFF00, after the above: credit saturates at 0xFFFF. A following order of 0xFFFF gives accept=1, remaining=0x0000.
- cancel_valid and order_valid asserted together in IDLE: cancel is taken first and order_ready=0 that cycle. The order is taken after 3 cycles and its response reflects the cancel already applied.
- Hold resp_ready=0 for 5 cycles: resp_valid and resp_* stay stable and order_ready=0 throughout. Raising resp_ready completes the handshake and order_ready returns 1 the next cycle.
- Assert reset during EXEC of an order: no response is issued, init_done=0, and after re-init the client's credit reads back as 0x0400.
